// File: rtl/wb_iq_sink_fifo.sv
// -----------------------------------------------------------------------------
// wb_iq_sink_fifo
//
// Wishbone-style streaming slave that terminates the 32-bit IQ stream of the
// OFDM TX chain, buffers samples in a small FIFO and replays each frame to the
// DAC side at one sample every DAC_DIV clocks.
//
// Frame handling:
//   - A frame is the set of transfers accepted while CYC_I is high. The falling
//     edge of CYC_I (after at least one transfer) marks end-of-frame.
//   - Playback starts once PREFILL samples are buffered, or at end-of-frame for
//     short frames. When the FIFO runs dry before end-of-frame, zero samples
//     are emitted and UNDERRUN is latched.
//   - The next frame is held off (ACK_O low) until the current frame has been
//     fully played out.
//
// Optional feature (compile-time macro IQ_GAIN2_EN):
//   defined   - each IQ component is doubled with saturation to 16-bit range.
//   undefined - samples pass through unchanged.
//
// Parameters:
//   AW       FIFO address width, DEPTH = 2**AW entries (usable DEPTH-1)
//   DAC_DIV  clocks per DAC output sample (>= 2)
//   PREFILL  samples buffered before playback starts (1..DEPTH-2)
//
// Ports:
//   CLK_I     in   system clock
//   RST_I     in   asynchronous reset, active-low
//   DAT_I     in   sample: [15:0] Re, [31:16] Im, two's complement
//   WE_I      in   write enable
//   STB_I     in   strobe
//   CYC_I     in   bus cycle, high for the whole frame
//   ACK_O     out  registered acknowledge
//   DAC_RE    out  DAC real part (held between pulses)
//   DAC_IM    out  DAC imaginary part (held between pulses)
//   DAC_VLD   out  one-cycle pulse per output sample
//   FRM_DONE  out  one-cycle pulse when a frame has been fully played
//   FRM_LEN   out  accepted-sample count of the last completed frame (sat.)
//   UNDERRUN  out  sticky underrun flag, cleared only by reset
// -----------------------------------------------------------------------------
module wb_iq_sink_fifo #(
    parameter int AW      = 4,
    parameter int DAC_DIV = 4,
    parameter int PREFILL = 8
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic [31:0] DAT_I,
    input  logic        WE_I,
    input  logic        STB_I,
    input  logic        CYC_I,
    output logic        ACK_O,
    output logic [15:0] DAC_RE,
    output logic [15:0] DAC_IM,
    output logic        DAC_VLD,
    output logic        FRM_DONE,
    output logic [15:0] FRM_LEN,
    output logic        UNDERRUN
);

    localparam int DEPTH = 1 << AW;
    localparam int CW    = AW + 1;
    localparam int DW    = $clog2(DAC_DIV);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_PLAY,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic [31:0]   rd_data;

    logic          push;
    logic          pop;
    logic          fifo_empty;
    logic          slot;
    logic          emit;
    logic          cyc_d;
    logic          eof_seen;
    logic          eof_next;
    logic [15:0]   len_cnt;
    logic [DW-1:0] div_cnt;

    // -------------------------------------------------------------------------
    // Output scaling. Overflow is detected when the two top bits differ: the
    // doubled value would no longer fit in 16 bits.
    // -------------------------------------------------------------------------
    function automatic logic [15:0] scale(input logic [15:0] x);
`ifdef IQ_GAIN2_EN
        if (x[15] != x[14]) begin
            return x[15] ? 16'h8000 : 16'h7FFF;
        end
        return {x[14:0], 1'b0};
`else
        return x;
`endif
    endfunction

    // -------------------------------------------------------------------------
    // Handshake and FIFO bookkeeping
    // -------------------------------------------------------------------------
    assign push       = WE_I & STB_I & CYC_I & ACK_O;
    assign fifo_empty = (count == '0);
    // Output slot: first clock of every DAC_DIV period while playing.
    assign slot       = (state == S_PLAY) && (div_cnt == '0);
    assign pop        = slot & ~fifo_empty;
    // A slot produces a DAC sample unless it is the terminating slot of the
    // frame (empty FIFO after end-of-frame), which moves to DONE instead.
    assign emit       = slot & ~(fifo_empty & eof_seen);
    assign rd_data    = mem[rd_ptr];

    assign count_next = count + CW'(push) - CW'(pop);

    always_comb begin
        if (state == S_DONE) begin
            eof_next = 1'b0;
        end else if (cyc_d && !CYC_I && (len_cnt != '0)) begin
            eof_next = 1'b1;
        end else begin
            eof_next = eof_seen;
        end
    end

    // -------------------------------------------------------------------------
    // Frame state machine
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next is assigned first so every path through the case
    // statement drives it and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (push) state_next = S_FILL;
            S_FILL: if ((count >= CW'(PREFILL)) || eof_seen) state_next = S_PLAY;
            S_PLAY: if (slot && fifo_empty && eof_seen) state_next = S_DONE;
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Sample storage
    // -------------------------------------------------------------------------
    // NOTE: the storage array has no reset; pointers and count define which
    // entries are valid, and leaving it unreset lets it map onto RAM.
    always_ff @(posedge CLK_I) begin
        if (push) begin
            mem[wr_ptr] <= DAT_I;
        end
    end

    // -------------------------------------------------------------------------
    // Control and output registers
    // -------------------------------------------------------------------------
    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            cyc_d    <= 1'b0;
            eof_seen <= 1'b0;
            len_cnt  <= '0;
            div_cnt  <= '0;
            ACK_O    <= 1'b0;
            DAC_RE   <= '0;
            DAC_IM   <= '0;
            DAC_VLD  <= 1'b0;
            FRM_DONE <= 1'b0;
            FRM_LEN  <= '0;
            UNDERRUN <= 1'b0;
        end else begin
            cyc_d    <= CYC_I;
            eof_seen <= eof_next;
            count    <= count_next;
            // Registered ACK: leaving one spare entry guarantees the push that
            // may land while this ACK is visible still fits.
            ACK_O    <= (count_next <= CW'(DEPTH - 2)) & ~eof_next;

            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;

            if (state == S_DONE) begin
                len_cnt <= '0;
            end else if (push && (len_cnt != 16'hFFFF)) begin
                len_cnt <= len_cnt + 16'd1;
            end

            // Divider runs only in PLAY; it is zero on entry, so the first
            // slot is the first PLAY clock.
            if (state == S_PLAY) begin
                div_cnt <= (div_cnt == DW'(DAC_DIV - 1)) ? '0 : div_cnt + 1'b1;
            end else begin
                div_cnt <= '0;
            end

            DAC_VLD <= emit;
            if (emit) begin
                DAC_RE <= pop ? scale(rd_data[15:0])  : 16'h0000;
                DAC_IM <= pop ? scale(rd_data[31:16]) : 16'h0000;
            end

            if (slot && fifo_empty && !eof_seen) begin
                UNDERRUN <= 1'b1;
            end

            // FRM_DONE and FRM_LEN change on the same edge so a consumer can
            // read the length together with the pulse.
            FRM_DONE <= (state == S_DONE);
            if (state == S_DONE) begin
                FRM_LEN <= len_cnt;
            end
        end
    end

endmodule

// File: tb/tb_wb_iq_sink_fifo.sv
// -----------------------------------------------------------------------------
// tb_wb_iq_sink_fifo
//
// Scoreboard bench: the source pushes each accepted sample (and each frame
// length) into expectation queues; an independent monitor pops and compares
// on every DAC_VLD / FRM_DONE pulse. Also checks pulse spacing, reset values,
// backpressure, underrun and frame hold-off.
// -----------------------------------------------------------------------------
module tb_wb_iq_sink_fifo;

    localparam int AW      = 4;
    localparam int DAC_DIV = 4;
    localparam int PREFILL = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] dat = '0;
    logic        we = 1'b0;
    logic        stb = 1'b0;
    logic        cyc = 1'b0;
    logic        ack;
    logic [15:0] dac_re;
    logic [15:0] dac_im;
    logic        dac_vld;
    logic        frm_done;
    logic [15:0] frm_len;
    logic        underrun;

    wb_iq_sink_fifo #(
        .AW      (AW),
        .DAC_DIV (DAC_DIV),
        .PREFILL (PREFILL)
    ) dut (
        .CLK_I    (clk),
        .RST_I    (rst_n),
        .DAT_I    (dat),
        .WE_I     (we),
        .STB_I    (stb),
        .CYC_I    (cyc),
        .ACK_O    (ack),
        .DAC_RE   (dac_re),
        .DAC_IM   (dac_im),
        .DAC_VLD  (dac_vld),
        .FRM_DONE (frm_done),
        .FRM_LEN  (frm_len),
        .UNDERRUN (underrun)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          cyc_n = 0;
    int          frames_done = 0;
    int          vld_cnt = 0;
    int          zero_cnt = 0;
    int          last_cyc = 0;
    bit          have_last = 1'b0;
    bit          zero_ok = 1'b0;
    bit          ack_low_seen = 1'b0;
    logic [31:0] exp_q[$];
    int          len_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    function automatic logic [15:0] exp_comp(input logic [15:0] x);
`ifdef IQ_GAIN2_EN
        if (x[15] != x[14]) return x[15] ? 16'h8000 : 16'h7FFF;
        return {x[14:0], 1'b0};
`else
        return x;
`endif
    endfunction

    function automatic logic [31:0] exp_out(input logic [31:0] s);
        return {exp_comp(s[31:16]), exp_comp(s[15:0])};
    endfunction

    // Distinct, never-zero sample pattern per test id.
    function automatic logic [31:0] pat(input int id, input int k);
        return {4'(id), 12'(k), 16'(32'h1000 + k)};
    endfunction

    // Cycle counter and monitor
    initial forever begin
        @(posedge clk);
        cyc_n++;
    end

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            have_last = 1'b0;
        end else begin
            if (cyc && stb && !ack) ack_low_seen = 1'b1;
            if (dac_vld) begin
                vld_cnt++;
                if (have_last) check("vld_spacing", 64'(cyc_n - last_cyc), 64'(DAC_DIV));
                have_last = 1'b1;
                last_cyc  = cyc_n;
                if (zero_ok && {dac_im, dac_re} == 32'h0) begin
                    zero_cnt++;
                end else if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_sample: got 0x%08h with nothing expected", {dac_im, dac_re});
                end else begin
                    check("dac_sample", {dac_im, dac_re}, exp_q.pop_front());
                end
            end
            if (frm_done) begin
                frames_done++;
                have_last = 1'b0;
                check("samples_left_at_done", exp_q.size(), 0);
                if (len_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_frm_done: got len %0d with no frame expected", frm_len);
                end else begin
                    check("frm_len", frm_len, len_q.pop_front());
                end
            end
        end
    end

    // Stimulus helpers (called at posedge + 1)
    task automatic xfer(input logic [31:0] d);
        int   guard;
        logic a;
        cyc   = 1'b1;
        stb   = 1'b1;
        we    = 1'b1;
        dat   = d;
        guard = 0;
        do begin
            @(negedge clk);
            a = ack;
            @(posedge clk);
            #1;
            guard++;
        end while (!a && guard < 3000);
        if (a) begin
            exp_q.push_back(exp_out(d));
        end else begin
            checks++;
            failures++;
            $display("FAIL ack_timeout: no ACK within %0d clocks", guard);
        end
    endtask

    task automatic end_frame(input int n);
        stb = 1'b0;
        we  = 1'b0;
        cyc = 1'b0;
        dat = '0;
        len_q.push_back(n);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_frames(input int target);
        int guard = 0;
        while (frames_done < target && guard < 4000) begin
            @(posedge clk);
            guard++;
        end
        #1;
        check("frames_done", frames_done, target);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ack"},      ack, 0);
        check({tag, "_dac_vld"},  dac_vld, 0);
        check({tag, "_dac_re"},   dac_re, 0);
        check({tag, "_dac_im"},   dac_im, 0);
        check({tag, "_frm_done"}, frm_done, 0);
        check({tag, "_frm_len"},  frm_len, 0);
        check({tag, "_underrun"}, underrun, 0);
    endtask

    initial begin
        int done0;
        int vc0;
        int g;

        // Reset state
        @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);

        // 20-sample frame, Re=k, Im=-k
        for (int k = 1; k <= 20; k++) xfer({16'(-k), 16'(k)});
        end_frame(20);
        wait_frames(1);
        check("underrun_after_frame1", underrun, 0);

        // Short frame below PREFILL
        for (int k = 1; k <= 3; k++) xfer(pat(2, k));
        end_frame(3);
        wait_frames(2);

        // Backpressure: 40 back-to-back samples
        ack_low_seen = 1'b0;
        for (int k = 1; k <= 40; k++) xfer(pat(3, k));
        end_frame(40);
        wait_frames(3);
        check("ack_backpressure_seen", ack_low_seen, 1);
        check("underrun_after_backpressure", underrun, 0);

        // Two frames separated by a 2-clock gap; frame 2 held until done
        for (int k = 1; k <= 8; k++) xfer(pat(4, k));
        end_frame(8);
        idle(2);
        xfer(pat(5, 1));
        check("ack_held_until_done", frames_done, 4);
        for (int k = 2; k <= 12; k++) xfer(pat(5, k));
        end_frame(12);
        wait_frames(5);
        check("underrun_after_two_frames", underrun, 0);

        // Source stall after 10 samples with CYC_I held high
        zero_ok  = 1'b1;
        zero_cnt = 0;
        for (int k = 1; k <= 10; k++) xfer(pat(6, k));
        stb = 1'b0;
        we  = 1'b0;
        idle(40);
        check("underrun_during_stall", underrun, 1);
        for (int k = 11; k <= 20; k++) xfer(pat(6, k));
        end_frame(20);
        wait_frames(6);
        zero_ok = 1'b0;
        check("underrun_zero_emitted", zero_cnt > 0, 1);
        idle(10);
        check("underrun_sticky", underrun, 1);

        // Reset during playback, then a fresh 5-sample frame
        for (int k = 1; k <= 12; k++) xfer(pat(7, k));
        end_frame(12);
        vc0 = vld_cnt;
        g   = 0;
        while (vld_cnt == vc0 && g < 500) begin
            @(posedge clk);
            g++;
        end
        #1;
        check("playing_before_reset", vld_cnt > vc0, 1);
        rst_n = 1'b0;
        exp_q.delete();
        len_q.delete();
        done0 = frames_done;
        @(negedge clk);
        check_outputs_zero("midreset");
        idle(2);
        rst_n = 1'b1;
        idle(1);
        for (int k = 1; k <= 5; k++) xfer(pat(8, k));
        end_frame(5);
        wait_frames(done0 + 1);
        idle(30);
        check("no_extra_frm_done", frames_done, done0 + 1);
        check("underrun_after_reset", underrun, 0);

        check("exp_q_empty_at_end", exp_q.size(), 0);
        check("len_q_empty_at_end", len_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_iq_sink_fifo.md
Name: wb_iq_sink_fifo

Overview:
- Wishbone-style streaming slave that terminates the 32-bit IQ output stream of the OFDM TX chain and buffers the samples in a FIFO.
- Replays each buffered frame to a DAC-side port at a fixed rate of one sample every DAC_DIV clocks.
- Reports frame completion, frame length and underruns.
- Sits between OFDM_TX_802_11 (DAT_O/WE_O/STB_O/CYC_O/ACK_I) and the DAC front end.

Parameters:
AW, 4, FIFO address width; DEPTH = 2**AW = 16 entries.
DAC_DIV, 4, clocks per DAC output sample (>=2).
PREFILL, 8, samples buffered before playback starts (1..DEPTH-2).

Ports:
CLK_I  in  1  system clock
RST_I  in  1  reset, asynchronous, active-low
DAT_I  in  32  sample; [15:0] Re, [31:16] Im, two's complement
WE_I  in  1  write enable
STB_I  in  1  strobe
CYC_I  in  1  cycle; held high for the whole frame, low between frames
ACK_O  out  1  registered acknowledge
DAC_RE  out  16  output real part
DAC_IM  out  16  output imaginary part
DAC_VLD  out  1  one-cycle pulse per output sample
FRM_DONE  out  1  one-cycle pulse at end of frame playback
FRM_LEN  out  16  accepted-sample count of the last completed frame
UNDERRUN  out  1  sticky; cleared only by reset

Behaviour:
- Reset (RST_I low, asynchronous): all outputs 0; FIFO empty; state IDLE; all counters 0.
- Transfer: a sample is accepted on a rising edge where WE_I&STB_I&CYC_I&ACK_O=1. It is pushed into the FIFO and increments len_cnt.
- ACK_O is registered: ACK_O <= (count_next <= DEPTH-2) & ~eof_seen. The FIFO never overflows; effective capacity is DEPTH-1.
- Frame end: on a CYC_I 1->0 transition with len_cnt>0, set eof_seen.
  - ACK_O stays 0 while eof_seen=1, so the next frame is held off until IDLE.
  - A CYC_I pulse with zero transfers is ignored.
- States:
  - IDLE: len_cnt=0, eof_seen=0. On the first accepted transfer -> FILL.
  - FILL: -> PLAY when FIFO count >= PREFILL, or when eof_seen=1 (short frame).
  - PLAY:
    - div_cnt counts 0..DAC_DIV-1 and wraps; it is set to 0 on entry.
    - On each cycle with div_cnt==0: if the FIFO is non-empty, pop. If the FIFO is empty and eof_seen=0, substitute 0 and set UNDERRUN.
    - Registered on the next edge: DAC_RE/DAC_IM <= popped/zero value, DAC_VLD <= 1.
    - DAC_VLD is 0 at all other times. DAC_RE/DAC_IM hold their values between pulses.
    - If the FIFO is empty, eof_seen=1 and div_cnt==0: -> DONE, with no pop.
  - DONE (one cycle): FRM_LEN <= len_cnt, FRM_DONE=1, clear len_cnt/eof_seen/div_cnt -> IDLE.
- Latency:
  - First DAC_VLD occurs 1 clock after entering PLAY.
  - Consecutive DAC_VLD pulses are exactly DAC_DIV clocks apart.
- Simultaneous push and pop in one cycle: count unchanged; both take effect.
- Transfers continue during FILL and PLAY until eof_seen.
- FIFO pointers are AW bits and wrap modulo DEPTH. count is AW+1 bits.
- FRM_LEN saturates at 16'hFFFF.
- A reset asserted mid-frame aborts playback immediately. No FRM_DONE is issued.

Optional Feature:
IQ_GAIN2_EN
- Defined: each component is doubled before registering to DAC_RE/DAC_IM, saturating to [-32768, 32767]. Example: 0x4000 -> 0x7FFF, 0xC000 -> 0x8000, 0x1234 -> 0x2468. Zero-substituted underrun samples remain 0.
- Undefined: samples pass through unchanged. No extra logic or latency either way.

Test Plan:
- 20-sample frame, values Re=k, Im=-k (k=1..20), continuous STB_I/WE_I, CYC_I drops after the 20th ACK -> 20 DAC_VLD pulses 4 clocks apart, in order, first value Re=1/Im=-1 -> one FRM_DONE with FRM_LEN=20, UNDERRUN=0.
- 3-sample frame (below PREFILL) -> playback starts after the CYC_I fall -> 3 pulses, FRM_LEN=3.
- Backpressure: 40 back-to-back samples with DAC_DIV=4 -> ACK_O deasserts once count reaches 15. No sample is lost or duplicated; the output sequence equals the input sequence.
- Source stalls 40 clocks after sample 10 with CYC_I held high -> zero samples are emitted, UNDERRUN=1 and stays 1. Playback resumes with sample 11; FRM_LEN=accepted count.
- RST_I pulled low during PLAY of frame 1, then frame 2 (5 samples) is sent -> all outputs 0 during reset, no FRM_DONE for frame 1; frame 2 gives 5 pulses and FRM_LEN=5.
- Two frames (8, 12 samples) separated by a 2-clock CYC_I gap -> ACK_O stays 0 until frame 1's FRM_DONE. FRM_LEN=8 then 12; data in frame order.
